// File: rtl/frag_id_ex_stage_pkg.sv
// frag_id_ex_stage_pkg: shared write-back bit positions, ALU opcodes and ID/EX control bundle.
package frag_id_ex_stage_pkg;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int ALU_W = 4;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd9;
  typedef struct packed {
    logic [ALU_W-1:0] alu_ctrl;
    logic             MemRead;
    logic             MemWrite;
    logic             branch;
    logic             jump;
    logic [1:0]       wb_ctrl;
  } idex_ctrl_t;
endpackage

// File: rtl/frag_id_ex_stage_hazard_detect.sv
// frag_hazard_detect: load-use interlock and PC / IF-ID stall generation.
module frag_hazard_detect (
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic       ex_MemRead,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_Rd,
  input  logic       id_valid,
  input  logic [4:0] id_Rs1,
  input  logic [4:0] id_Rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       mem_stall,
  input  logic       ex_redirect,
  output logic       load_use,
  output logic       stall
);
  logic src_hit;
  assign src_hit  = (id_use_rs1 && ex_Rd == id_Rs1) || (id_use_rs2 && ex_Rd == id_Rs2);
  assign load_use = ex_valid & ex_MemRead & ex_regwrite & (ex_Rd != 5'd0) & src_hit & id_valid;
  // A redirect already flushes IF/ID, so the interlock must not also freeze it.
  assign stall    = rst_n & (mem_stall | (load_use & ~ex_redirect));
endmodule

// File: rtl/frag_id_ex_stage.sv
// frag_id_ex_stage: ID/EX pipeline register with hold, flush/interlock bubbles and WB-to-ID bypass.
module frag_id_ex_stage
  import frag_id_ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [4:0]            id_Rs1,
  input  logic [4:0]            id_Rs2,
  input  logic [4:0]            id_Rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic                  id_MemRead,
  input  logic                  id_MemWrite,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic [1:0]            id_wb_ctrl,
  input  logic [4:0]            wb_Rd,
  input  logic [1:0]            wb_wb_ctrl,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  ex_redirect,
  input  logic                  mem_stall,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [4:0]            ex_Rs1,
  output logic [4:0]            ex_Rs2,
  output logic [4:0]            ex_Rd,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [1:0]            ex_wb_ctrl,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  load_use
);
  logic            valid_q, valid_d, bubble, stall;
  logic [XLEN-1:0] pc_q, rs1_q, rs1_d, rs2_q, rs2_d, imm_q;
  logic [4:0]      rs1i_q, rs2i_q, rd_q;
  idex_ctrl_t      ctrl_q, ctrl_d;

  frag_hazard_detect u_hazard (
    .rst_n       (rst_n),
    .ex_valid    (valid_q),
    .ex_MemRead  (ctrl_q.MemRead),
    .ex_regwrite (ctrl_q.wb_ctrl[WB_REGWRITE]),
    .ex_Rd       (rd_q),
    .id_valid    (id_valid),
    .id_Rs1      (id_Rs1),
    .id_Rs2      (id_Rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .mem_stall   (mem_stall),
    .ex_redirect (ex_redirect),
    .load_use    (load_use),
    .stall       (stall)
  );

  // Register-file write and read land in the same cycle; steer the WB value in directly.
  always_comb begin
    bubble  = ex_redirect | load_use;
    valid_d = id_valid & ~bubble;
    ctrl_d  = '{alu_ctrl: ALU_W'(id_alu_ctrl),
                MemRead:  id_MemRead & ~bubble,
                MemWrite: id_MemWrite & ~bubble,
                branch:   id_branch & ~bubble,
                jump:     id_jump & ~bubble,
                wb_ctrl:  id_wb_ctrl & {2{~bubble}}};
    rs1_d   = (wb_wb_ctrl[WB_REGWRITE] && wb_Rd != 5'd0 && wb_Rd == id_Rs1) ? wb_data : id_rs1_data;
    rs2_d   = (wb_wb_ctrl[WB_REGWRITE] && wb_Rd != 5'd0 && wb_Rd == id_Rs2) ? wb_data : id_rs2_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      rs1i_q  <= '0;
      rs2i_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (!mem_stall) begin
      valid_q <= valid_d;
      pc_q    <= id_pc;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= id_imm;
      rs1i_q  <= id_Rs1;
      rs2i_q  <= id_Rs2;
      rd_q    <= id_Rd;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_q;
  assign ex_rs2_data = rs2_q;
  assign ex_imm      = imm_q;
  assign ex_Rs1      = rs1i_q;
  assign ex_Rs2      = rs2i_q;
  assign ex_Rd       = rd_q;
  assign ex_alu_ctrl = ALU_CTRL_W'(ctrl_q.alu_ctrl);
  assign ex_MemRead  = ctrl_q.MemRead;
  assign ex_MemWrite = ctrl_q.MemWrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_jump     = ctrl_q.jump;
  assign ex_wb_ctrl  = ctrl_q.wb_ctrl;
  assign stall_pc    = stall;
  assign stall_ifid  = stall;
endmodule

// File: tb/tb_frag_id_ex_stage.sv
// tb_frag_id_ex_stage: directed-vector bench for the ID/EX register, interlock and bypass.
module tb_frag_id_ex_stage;
  logic        clk = 1'b0, rst_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_MemRead, id_MemWrite, id_branch, id_jump;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]  id_Rs1, id_Rs2, id_Rd, wb_Rd;
  logic [3:0]  id_alu_ctrl;
  logic [1:0]  id_wb_ctrl, wb_wb_ctrl;
  logic        ex_redirect, mem_stall;
  logic        ex_valid, ex_MemRead, ex_MemWrite, ex_branch, ex_jump;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_Rs1, ex_Rs2, ex_Rd;
  logic [3:0]  ex_alu_ctrl;
  logic [1:0]  ex_wb_ctrl;
  logic        stall_pc, stall_ifid, load_use;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  frag_id_ex_stage #(.XLEN(32), .ALU_CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_Rd(id_Rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_alu_ctrl(id_alu_ctrl),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_branch(id_branch), .id_jump(id_jump),
    .id_wb_ctrl(id_wb_ctrl), .wb_Rd(wb_Rd), .wb_wb_ctrl(wb_wb_ctrl), .wb_data(wb_data),
    .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_Rs1(ex_Rs1), .ex_Rs2(ex_Rs2), .ex_Rd(ex_Rd), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_wb_ctrl(ex_wb_ctrl), .stall_pc(stall_pc), .stall_ifid(stall_ifid), .load_use(load_use)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 1'b1; ex_redirect = 1'b0;
    id_valid = 1'b1; id_pc = 32'h50; id_rs1_data = 32'h1; id_rs2_data = 32'h2; id_imm = 32'h3;
    id_Rs1 = 5'd1; id_Rs2 = 5'd2; id_Rd = 5'd3; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_alu_ctrl = 4'd1; id_MemRead = 1'b1; id_MemWrite = 1'b1; id_branch = 1'b1; id_jump = 1'b1;
    id_wb_ctrl = 2'b11; wb_Rd = 5'd0; wb_wb_ctrl = 2'b00; wb_data = 32'h0;
    tick(); tick();
    chk("reset_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_pc", ex_pc, 32'h0);
    chk("reset_ctrl", {ex_alu_ctrl, ex_MemRead, ex_MemWrite, ex_branch, ex_jump, ex_wb_ctrl}, 32'd0);
    chk("reset_stall_pc", {31'b0, stall_pc}, 32'd0);
    chk("reset_load_use", {31'b0, load_use}, 32'd0);
    rst_n = 1'b1; mem_stall = 1'b0;
    id_MemWrite = 1'b0; id_branch = 1'b0; id_jump = 1'b0; id_MemRead = 1'b0;
    id_pc = 32'h100; id_Rd = 5'd5; id_wb_ctrl = 2'b10; id_imm = 32'h44;
    tick();
    chk("load_pc", ex_pc, 32'h100);
    chk("load_rd", {27'b0, ex_Rd}, 32'd5);
    chk("load_valid", {31'b0, ex_valid}, 32'd1);
    chk("load_imm", ex_imm, 32'h44);
    chk("load_alu", {28'b0, ex_alu_ctrl}, 32'd1);
    // lw x5 into EX, then add x6,x5,x7 in ID
    id_pc = 32'h104; id_Rd = 5'd5; id_MemRead = 1'b1; id_wb_ctrl = 2'b11;
    tick();
    chk("lw_memread", {31'b0, ex_MemRead}, 32'd1);
    id_pc = 32'h108; id_Rd = 5'd6; id_Rs1 = 5'd5; id_Rs2 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_MemRead = 1'b0; id_wb_ctrl = 2'b10;
    #1;
    chk("lu_load_use", {31'b0, load_use}, 32'd1);
    chk("lu_stall_pc", {31'b0, stall_pc}, 32'd1);
    chk("lu_stall_ifid", {31'b0, stall_ifid}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu_bubble_memread", {31'b0, ex_MemRead}, 32'd0);
    chk("lu_bubble_wb", {30'b0, ex_wb_ctrl}, 32'd0);
    chk("lu_release", {31'b0, load_use}, 32'd0);
    chk("lu_release_stall", {31'b0, stall_pc}, 32'd0);
    tick();
    chk("lu_add_pc", ex_pc, 32'h108);
    chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
    // load to x0 with dependent x0 read
    id_Rd = 5'd0; id_MemRead = 1'b1; id_wb_ctrl = 2'b11; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    tick();
    id_Rd = 5'd6; id_MemRead = 1'b0; id_wb_ctrl = 2'b10; id_Rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    chk("x0_load_use", {31'b0, load_use}, 32'd0);
    // load x9 then ID names x9 in Rs2 without reading it
    id_Rd = 5'd9; id_MemRead = 1'b1; id_wb_ctrl = 2'b11; id_use_rs1 = 1'b0;
    tick();
    id_Rd = 5'd6; id_MemRead = 1'b0; id_wb_ctrl = 2'b10; id_pc = 32'h120;
    id_Rs1 = 5'd1; id_use_rs1 = 1'b1; id_Rs2 = 5'd9; id_use_rs2 = 1'b0;
    #1;
    chk("unused_rs2_load_use", {31'b0, load_use}, 32'd0);
    id_use_rs2 = 1'b1;
    #1;
    chk("used_rs2_load_use", {31'b0, load_use}, 32'd1);
    ex_redirect = 1'b1;
    #1;
    chk("redir_lu_stall_pc", {31'b0, stall_pc}, 32'd0);
    chk("redir_lu_stall_ifid", {31'b0, stall_ifid}, 32'd0);
    tick();
    chk("redir_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("redir_bubble_memread", {31'b0, ex_MemRead}, 32'd0);
    ex_redirect = 1'b0;
    // WB bypass on Rs2
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_Rs1 = 5'd4; id_Rs2 = 5'd3;
    id_rs1_data = 32'h11; id_rs2_data = 32'h0;
    wb_Rd = 5'd3; wb_wb_ctrl = 2'b10; wb_data = 32'hDEADBEEF;
    tick();
    chk("byp_rs2", ex_rs2_data, 32'hDEADBEEF);
    chk("byp_rs1_untouched", ex_rs1_data, 32'h11);
    wb_Rd = 5'd0; id_Rs2 = 5'd0;
    tick();
    chk("byp_x0", ex_rs2_data, 32'h0);
    wb_Rd = 5'd4;
    tick();
    chk("byp_rs1", ex_rs1_data, 32'hDEADBEEF);
    wb_wb_ctrl = 2'b01;
    tick();
    chk("byp_noregwrite", ex_rs1_data, 32'h11);
    wb_wb_ctrl = 2'b00;
    // hold beats redirect
    id_pc = 32'h200; id_Rd = 5'd8; id_MemRead = 1'b1; id_wb_ctrl = 2'b11; id_valid = 1'b1;
    tick();
    chk("pre_hold_pc", ex_pc, 32'h200);
    id_pc = 32'h300; id_Rd = 5'd12; id_MemRead = 1'b0; id_wb_ctrl = 2'b10;
    mem_stall = 1'b1; ex_redirect = 1'b1;
    #1;
    chk("hold_stall_pc", {31'b0, stall_pc}, 32'd1);
    tick();
    chk("hold_pc", ex_pc, 32'h200);
    chk("hold_valid", {31'b0, ex_valid}, 32'd1);
    chk("hold_memread", {31'b0, ex_MemRead}, 32'd1);
    chk("hold_rd", {27'b0, ex_Rd}, 32'd8);
    // async reset mid-stall
    ex_redirect = 1'b0; id_pc = 32'h400; id_Rd = 5'd10;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_pc", ex_pc, 32'h0);
    chk("areset_valid", {31'b0, ex_valid}, 32'd0);
    chk("areset_rd", {27'b0, ex_Rd}, 32'd0);
    chk("areset_stall_pc", {31'b0, stall_pc}, 32'd0);
    mem_stall = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_reset_pc", ex_pc, 32'h400);
    chk("post_reset_valid", {31'b0, ex_valid}, 32'd1);
    chk("post_reset_rd", {27'b0, ex_Rd}, 32'd10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
